estimate_seq: RTL and testbench

- Command sequencer directly upstream of the binarized-CNN estimate array.
- Drives the array's com/addr/data bus to compute one conv+pool+norm+activation output word per output pixel.
- Pulls 64-bit input feature words from a valid/ready stream, one per acc step, and weight addresses for the array's parameter ROM.
- Captures the array's 64-bit activ result into a single-entry output register presented on a valid/ready stream.

---
 rtl/estimate_seq.sv | 178 +++++++++++++++++
 tb/tb_estimate_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/estimate_seq.sv
// estimate_seq
// Command sequencer for the binarized-CNN estimate array. For every output pixel it
// drives the array's com/addr/data bus through ini, POOL groups of NACC acc steps each
// followed by one pool step, then norm and activ. It captures the array's activ result
// into a single-entry output register that is drained over a valid/ready stream.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start, num_pix        begin a run of num_pix output pixels (sampled only in IDLE)
//   busy, done            run in progress / one-cycle completion pulse
//   in_data/valid/ready   input feature word stream, one word per acc step
//   com, addr, data       registered array command bus (7 = nop)
//   activ                 array result, valid ACT_LAT cycles after com=4 is on the bus
//   out_data/valid/ready  captured activation word stream
module estimate_seq #(
    parameter int NACC      = 9,
    parameter int POOL      = 4,
    parameter int W_BASE    = 0,
    parameter int NORM_ADDR = 9,
    parameter int ACT_LAT   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] num_pix,
    output logic        busy,
    output logic        done,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [2:0]  com,
    output logic [15:0] addr,
    output logic [63:0] data,
    input  logic [63:0] activ,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [2:0] COM_INI   = 3'd0;
    localparam logic [2:0] COM_ACC   = 3'd1;
    localparam logic [2:0] COM_POOL  = 3'd2;
    localparam logic [2:0] COM_NORM  = 3'd3;
    localparam logic [2:0] COM_ACTIV = 3'd4;
    localparam logic [2:0] COM_NOP   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INI,
        S_ACC,
        S_POOL,
        S_NORM,
        S_ACTIV,
        S_WAIT
    } state_t;

    state_t      state;
    logic [15:0] k;
    logic [15:0] p;
    logic [15:0] lat;
    logic [15:0] pix;
    logic [15:0] num_pix_q;

    // Input words are only taken while accumulating.
    assign in_ready = (state == S_ACC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            com       <= COM_NOP;
            addr      <= '0;
            data      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            k         <= '0;
            p         <= '0;
            lat       <= '0;
            pix       <= '0;
            num_pix_q <= '0;
        end else begin
            // Bus idles as nop with zero addr/data unless a state issues a command.
            com  <= COM_NOP;
            addr <= '0;
            data <= '0;
            done <= 1'b0;

            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_pix_q <= num_pix;
                        pix       <= '0;
                        if (num_pix == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_INI;
                        end
                    end
                end

                S_INI: begin
                    com   <= COM_INI;
                    k     <= '0;
                    p     <= '0;
                    state <= S_ACC;
                end

                S_ACC: begin
                    if (in_valid) begin
                        com  <= COM_ACC;
                        addr <= 16'(W_BASE) + k;
                        data <= in_data;
                        k    <= k + 16'd1;
                        if (k == 16'(NACC - 1))
                            state <= S_POOL;
                    end else begin
                        // Stall: nop on the bus, weight address held.
                        addr <= addr;
                    end
                end

                S_POOL: begin
                    com <= COM_POOL;
                    p   <= p + 16'd1;
                    k   <= '0;
                    if (p == 16'(POOL - 1))
                        state <= S_NORM;
                    else
                        state <= S_ACC;
                end

                S_NORM: begin
                    com   <= COM_NORM;
                    addr  <= 16'(NORM_ADDR);
                    state <= S_ACTIV;
                end

                // The output register has one entry, so a new activation may only be
                // requested once the previous one has been drained.
                S_ACTIV: begin
                    if (!out_valid) begin
                        com   <= COM_ACTIV;
                        addr  <= 16'(NORM_ADDR);
                        lat   <= '0;
                        state <= S_WAIT;
                    end
                end

                // lat counts the cycles since com=4 reached the bus; activ is valid
                // in the cycle where lat equals ACT_LAT.
                S_WAIT: begin
                    if (lat == 16'(ACT_LAT)) begin
                        out_data  <= activ;
                        out_valid <= 1'b1;
                        pix       <= pix + 16'd1;
                        if (pix + 16'd1 == num_pix_q) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_INI;
                        end
                    end else begin
                        lat <= lat + 16'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_estimate_seq.sv
// tb_estimate_seq
// Directed bench for estimate_seq. A small behavioural model of the estimate array
// folds the acc/pool/norm commands it sees on the bus into an accumulator and returns
// it on activ exactly ACT_LAT cycles after com=4. Expected results are folded
// independently from the input word list the bench feeds.
module tb_estimate_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_pix;
    logic        busy;
    logic        done;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  com;
    logic [15:0] addr;
    logic [63:0] data;
    logic [63:0] activ = '0;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    estimate_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_pix   (num_pix),
        .busy      (busy),
        .done      (done),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .com       (com),
        .addr      (addr),
        .data      (data),
        .activ     (activ),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int words_taken = 0;
    int stall_left = 0;
    int stall_at = 0;

    function automatic logic [63:0] rotl(input logic [63:0] v, input int s);
        return (v << s) | (v >> (64 - s));
    endfunction

    function automatic logic [63:0] mk_word(input int i);
        return (64'h9E37_79B9_7F4A_7C15 * 64'(i + 1)) ^ {32'(i), 32'hC0FF_EE00};
    endfunction

    // Expected activation for a pixel whose 36 input words start at index base.
    function automatic logic [63:0] expect_pixel(input int base);
        logic [63:0] acc;
        acc = '0;
        for (int pp = 0; pp < 4; pp++) begin
            for (int kk = 0; kk < 9; kk++)
                acc = rotl(acc, 1) ^ mk_word(base + pp * 9 + kk) ^ 64'(kk);
            acc = rotl(acc, 3);
        end
        return acc ^ 64'd9;
    endfunction

    // Array model: accumulator plus a latency pipe from com=4 to activ.
    logic [63:0] m_acc = '0;
    logic [63:0] s1_d = '0, s2_d = '0;
    logic        s1_v = 1'b0, s2_v = 1'b0;

    always @(posedge clk) begin
        case (com)
            3'd0: m_acc <= '0;
            3'd1: m_acc <= rotl(m_acc, 1) ^ data ^ {48'd0, addr};
            3'd2: m_acc <= rotl(m_acc, 3);
            3'd3: m_acc <= m_acc ^ {48'd0, addr};
            default: ;
        endcase
        s1_v  <= (com == 3'd4);
        s1_d  <= m_acc;
        s2_v  <= s1_v;
        s2_d  <= s1_d;
        activ <= s2_v ? s2_d : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    always @(posedge clk)
        if (in_valid && in_ready)
            words_taken <= words_taken + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        in_data = mk_word(words_taken);
        if (stall_left > 0 && words_taken == stall_at) begin
            in_valid = 1'b0;
            stall_left--;
        end else begin
            in_valid = 1'b1;
        end
    endtask

    logic [18:0] trace[$];
    logic [18:0] exp_trace[$];
    logic [63:0] outs_q[$];
    int          c4_q[$];
    int          rise_q[$];
    int          done_q[$];
    int          hs_q[$];
    int          run_base;
    int          data_err;
    int          stable_err;
    bit          run_finished;
    logic        busy_first;

    // Run num pixels; stall_k >= 0 drops in_valid for 3 cycles at that acc step,
    // hold > 0 keeps out_ready low for hold cycles after the first out_valid,
    // inject pulses start mid-run.
    task automatic applyStimulus(input int n, input int stall_k, input int hold, input bit inject);
        int   t0, rel, n_acc, release_at;
        bit   released;
        logic prev_ov;
        logic [63:0] prev_od;
        trace.delete(); outs_q.delete(); c4_q.delete();
        rise_q.delete(); done_q.delete(); hs_q.delete();
        run_base     = words_taken;
        data_err     = 0;
        stable_err   = 0;
        run_finished = 1'b0;
        n_acc        = 0;
        released     = (hold == 0);
        release_at   = -1;
        prev_ov      = out_valid;
        prev_od      = out_data;
        stall_left   = (stall_k >= 0) ? 3 : 0;
        stall_at     = run_base + stall_k;
        out_ready    = released;
        start        = 1'b1;
        num_pix      = 16'(n);
        tick();
        start        = 1'b0;
        t0           = cyc;
        busy_first   = busy;
        for (int i = 0; i < 600 && !run_finished; i++) begin
            rel = cyc - t0;
            if (com != 3'd7) trace.push_back({com, addr});
            if (com == 3'd1) begin
                if (data !== mk_word(run_base + n_acc)) data_err++;
                n_acc++;
            end
            if (com == 3'd4) c4_q.push_back(rel);
            if (out_valid && !prev_ov) begin
                rise_q.push_back(rel);
                outs_q.push_back(out_data);
                if (!released && release_at < 0) release_at = cyc + hold;
            end
            if (out_valid && prev_ov && out_data !== prev_od) stable_err++;
            prev_ov = out_valid;
            prev_od = out_data;
            if (done) begin
                done_q.push_back(rel);
                run_finished = 1'b1;
            end
            start = inject && (rel == 20);
            if (start) num_pix = 16'd5;
            if (release_at >= 0 && cyc >= release_at) released = 1'b1;
            out_ready = released;
            if (out_valid && out_ready) hs_q.push_back(rel);
            tick();
        end
        start = 1'b0;
        checkOutput("run_done", 64'(run_finished), 64'd1);
    endtask

    task automatic checkTrace(input string tag);
        exp_trace.delete();
        exp_trace.push_back({3'd0, 16'd0});
        for (int g = 0; g < 4; g++) begin
            for (int kk = 0; kk < 9; kk++) exp_trace.push_back({3'd1, 16'(kk)});
            exp_trace.push_back({3'd2, 16'd0});
        end
        exp_trace.push_back({3'd3, 16'd9});
        exp_trace.push_back({3'd4, 16'd9});
        checkOutput({tag, "_len"}, 64'(trace.size()), 64'(exp_trace.size()));
        for (int i = 0; i < exp_trace.size(); i++)
            checkOutput($sformatf("%s_%0d", tag, i),
                        (i < trace.size()) ? 64'(trace[i]) : 64'h7FFFF, 64'(exp_trace[i]));
    endtask

    initial begin
        int non_nop;
        reset     = 1'b1;
        start     = 1'b0;
        num_pix   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("rst_com", 64'(com), 64'd7);
        checkOutput("rst_addr", 64'(addr), 64'd0);
        checkOutput("rst_data", data, 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();

        $display("[TB] num_pix=0 run");
        non_nop = 0;
        start   = 1'b1;
        num_pix = 16'd0;
        tick();
        start = 1'b0;
        checkOutput("zero_done", 64'(done), 64'd1);
        checkOutput("zero_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (com != 3'd7 || in_ready) non_nop++;
            tick();
        end
        checkOutput("zero_done_pulse", 64'(done), 64'd0);
        checkOutput("zero_no_cmd", 64'(non_nop), 64'd0);

        $display("[TB] reset mid-ACC");
        start   = 1'b1;
        num_pix = 16'd1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        reset = 1'b1;
        tick();
        checkOutput("midrst_com", 64'(com), 64'd7);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] single pixel, no stall");
        applyStimulus(1, -1, 0, 1'b0);
        checkOutput("s_busy_first", 64'(busy_first), 64'd1);
        checkTrace("s_trace");
        checkOutput("s_data_err", 64'(data_err), 64'd0);
        checkOutput("s_c4", (c4_q.size() > 0) ? 64'(c4_q[0]) : 64'hFFFF, 64'd43);
        checkOutput("s_rise", (rise_q.size() > 0) ? 64'(rise_q[0]) : 64'hFFFF, 64'd47);
        checkOutput("s_done", (done_q.size() > 0) ? 64'(done_q[0]) : 64'hFFFF, 64'd47);
        checkOutput("s_out_data", (outs_q.size() > 0) ? outs_q[0] : 64'hDEAD, expect_pixel(run_base));
        checkOutput("s_words", 64'(words_taken - run_base), 64'd36);
        checkOutput("s_busy_after", 64'(busy), 64'd0);

        $display("[TB] single pixel, input stall at k=4");
        applyStimulus(1, 4, 0, 1'b0);
        checkTrace("st_trace");
        checkOutput("st_data_err", 64'(data_err), 64'd0);
        checkOutput("st_c4", (c4_q.size() > 0) ? 64'(c4_q[0]) : 64'hFFFF, 64'd46);
        checkOutput("st_rise", (rise_q.size() > 0) ? 64'(rise_q[0]) : 64'hFFFF, 64'd50);
        checkOutput("st_out_data", (outs_q.size() > 0) ? outs_q[0] : 64'hDEAD, expect_pixel(run_base));
        checkOutput("st_words", 64'(words_taken - run_base), 64'd36);

        $display("[TB] two pixels, output back-pressure, start while busy");
        applyStimulus(2, -1, 60, 1'b1);
        checkOutput("bp_data_err", 64'(data_err), 64'd0);
        checkOutput("bp_c4_count", 64'(c4_q.size()), 64'd2);
        checkOutput("bp_c4_first", (c4_q.size() > 0) ? 64'(c4_q[0]) : 64'hFFFF, 64'd43);
        checkOutput("bp_hs_first", (hs_q.size() > 0) ? 64'(hs_q[0]) : 64'hFFFF, 64'd107);
        checkOutput("bp_c4_second", (c4_q.size() > 1) ? 64'(c4_q[1]) : 64'hFFFF, 64'd109);
        checkOutput("bp_stable_err", 64'(stable_err), 64'd0);
        checkOutput("bp_rise_count", 64'(rise_q.size()), 64'd2);
        checkOutput("bp_rise_second", (rise_q.size() > 1) ? 64'(rise_q[1]) : 64'hFFFF, 64'd113);
        checkOutput("bp_done", (done_q.size() > 0) ? 64'(done_q[0]) : 64'hFFFF, 64'd113);
        checkOutput("bp_out0", (outs_q.size() > 0) ? outs_q[0] : 64'hDEAD, expect_pixel(run_base));
        checkOutput("bp_out1", (outs_q.size() > 1) ? outs_q[1] : 64'hDEAD, expect_pixel(run_base + 36));
        checkOutput("bp_words", 64'(words_taken - run_base), 64'd72);
        checkOutput("bp_busy_after", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
